// File: rtl/cpu_pkg.sv
// cpu_pkg -- shared definitions for the multi-cycle MIPS core control path.
//
// Contents:
//   state_t           instruction-cycle state encoding used by cpu_sequencer
//   CPU_RESET_VECTOR  first fetch address after reset (shared with the PC)
//   CPU_ISR_VECTOR    interrupt service routine entry (shared with the PC)
//   is_terminal()     true for states that only reset can leave
package cpu_pkg;

  typedef enum logic [2:0] {
    BOOT   = 3'd0,
    FETCH  = 3'd1,
    EXEC1  = 3'd2,
    STALL  = 3'd3,
    EXEC2  = 3'd4,
    HALTED = 3'd5,
    FAULT  = 3'd6
  } state_t;

  localparam logic [31:0] CPU_RESET_VECTOR = 32'hBFC00000;
  localparam logic [31:0] CPU_ISR_VECTOR   = 32'hBFCF0000;

  function automatic logic is_terminal(input state_t s);
    return (s == HALTED) || (s == FAULT);
  endfunction

endpackage

// File: rtl/irq_scheduler.sv
// irq_scheduler -- interrupt edge detection, pending flag and delivery pulse.
//
// Ports:
//   clk            in   system clock
//   reset          in   asynchronous active-low reset
//   interrupt_req  in   external interrupt request (level)
//   deliver_window in   high for the first cycle of EXEC1 only
//   flush          in   drop any pending request (core is about to stop)
//   irq_pulse      out  one-cycle notification to the PC
module irq_scheduler (
  input  logic clk,
  input  logic reset,
  input  logic interrupt_req,
  input  logic deliver_window,
  input  logic flush,
  output logic irq_pulse
);

  logic irq_d_reg;
  logic pending_reg;
  logic pending_next;
  logic irq_edge;

  // Rising edge: request high now, low on the previous cycle.
  assign irq_edge  = interrupt_req & ~irq_d_reg;
  // Both terms are registers, so the pulse cannot glitch.
  assign irq_pulse = deliver_window & pending_reg;

  // A new edge wins over the clear caused by delivery, so an edge landing in
  // the delivery cycle is kept for the next instruction.
  always_comb begin
    pending_next = pending_reg;
    if (flush) begin
      pending_next = 1'b0;
    end else if (irq_edge) begin
      pending_next = 1'b1;
    end else if (irq_pulse) begin
      pending_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_d_reg   <= 1'b0;
      pending_reg <= 1'b0;
    end else begin
      irq_d_reg   <= interrupt_req;
      pending_reg <= pending_next;
    end
  end

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer -- instruction-cycle controller for the multi-cycle MIPS core.
//
// Parameters:
//   STALL_TIMEOUT  consecutive stalled cycles in one state that fault the core (>= 1)
//   CNT_W          width of instr_count
//
// Ports:
//   clk, reset (async active-low)
//   waitrequest, data_access, long_op_busy, pc_halt, interrupt_req   inputs
//   fetch, exec1, exec2        one-hot state strobes (Moore)
//   mem_fetch_req              instruction read request (FETCH)
//   irq_pulse                  interrupt notification on first EXEC1 cycle
//   active                     executing (FETCH/EXEC1/STALL/EXEC2)
//   timeout_fault              sticky watchdog fault
//   instr_count                retired instruction count, wraps
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int STALL_TIMEOUT = 1023,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             waitrequest,
  input  logic             data_access,
  input  logic             long_op_busy,
  input  logic             pc_halt,
  input  logic             interrupt_req,
  output logic             fetch,
  output logic             exec1,
  output logic             exec2,
  output logic             mem_fetch_req,
  output logic             irq_pulse,
  output logic             active,
  output logic             timeout_fault,
  output logic [CNT_W-1:0] instr_count
);

  localparam int               SC_W   = $clog2(STALL_TIMEOUT + 1);
  localparam logic [SC_W-1:0]  SC_MAX = SC_W'(STALL_TIMEOUT);

  state_t            state_reg, state_next;
  logic [SC_W-1:0]   stall_cnt_reg, stall_cnt_next, stall_cnt_inc;
  logic [CNT_W-1:0]  count_reg;
  logic              deliver_reg, deliver_next;
  logic              stalling;
  logic              stall_hit;
  logic              flush;

  // A cycle counts as stalled when the state is being held for a bus or
  // functional unit. Every STALL cycle counts, including the exit cycle.
  always_comb begin
    stalling = 1'b0;
    case (state_reg)
      FETCH:   stalling = waitrequest;
      EXEC1:   stalling = data_access & waitrequest;
      STALL:   stalling = 1'b1;
      default: stalling = 1'b0;
    endcase
  end

  // Saturating increment; the counter never wraps.
  assign stall_cnt_inc = (stall_cnt_reg == SC_MAX) ? SC_MAX : stall_cnt_reg + 1'b1;
  // This cycle brings the count to the limit: leave for FAULT on this edge,
  // so a stall one cycle shorter than the limit still progresses normally.
  assign stall_hit     = stalling && (stall_cnt_inc == SC_MAX);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      BOOT:   state_next = FETCH;
      FETCH: begin
        if (stall_hit)        state_next = FAULT;
        else if (waitrequest) state_next = FETCH;
        else                  state_next = EXEC1;
      end
      EXEC1: begin
        if (stall_hit)                        state_next = FAULT;
        else if (data_access && waitrequest)  state_next = EXEC1;
        else if (long_op_busy)                state_next = STALL;
        else                                  state_next = EXEC2;
      end
      STALL: begin
        if (stall_hit)         state_next = FAULT;
        else if (long_op_busy) state_next = STALL;
        else                   state_next = EXEC2;
      end
      EXEC2:  state_next = pc_halt ? HALTED : FETCH;
      HALTED: state_next = HALTED;
      FAULT:  state_next = FAULT;
      default: state_next = BOOT;
    endcase
  end

  // Any state change clears the watchdog.
  assign stall_cnt_next = (stalling && (state_next == state_reg)) ? stall_cnt_inc : '0;

  // Delivery window is registered so it is high exactly on EXEC1 entry.
  assign deliver_next = (state_next == EXEC1) && (state_reg != EXEC1);
  assign flush        = is_terminal(state_next);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= BOOT;
      stall_cnt_reg <= '0;
      count_reg     <= '0;
      deliver_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      stall_cnt_reg <= stall_cnt_next;
      deliver_reg   <= deliver_next;
      if (state_reg == EXEC2) begin
        count_reg <= count_reg + 1'b1;
      end
    end
  end

  // Moore strobes decoded from the state register only.
  always_comb begin
    fetch         = 1'b0;
    exec1         = 1'b0;
    exec2         = 1'b0;
    mem_fetch_req = 1'b0;
    active        = 1'b0;
    timeout_fault = 1'b0;
    case (state_reg)
      FETCH: begin
        fetch         = 1'b1;
        mem_fetch_req = 1'b1;
        active        = 1'b1;
      end
      EXEC1: begin
        exec1  = 1'b1;
        active = 1'b1;
      end
      STALL:  active = 1'b1;
      EXEC2: begin
        exec2  = 1'b1;
        active = 1'b1;
      end
      FAULT:  timeout_fault = 1'b1;
      default: ;
    endcase
  end

  assign instr_count = count_reg;

  irq_scheduler u_irq (
    .clk            (clk),
    .reset          (reset),
    .interrupt_req  (interrupt_req),
    .deliver_window (deliver_reg),
    .flush          (flush),
    .irq_pulse      (irq_pulse)
  );

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer -- self-checking bench for cpu_sequencer.
// Each instruction is described by its stall lengths; the bench expands that
// into the expected per-cycle phase sequence and the inputs that produce it.
module tb_cpu_sequencer;

  localparam int TO = 8;
  localparam int CW = 4;

  localparam int K_BOOT = 0, K_FETCH = 1, K_E1 = 2, K_STALL = 3,
                 K_E2 = 4, K_HALT = 5, K_FAULT = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          waitrequest = 1'b0, data_access = 1'b0, long_op_busy = 1'b0;
  logic          pc_halt = 1'b0, interrupt_req = 1'b0;
  logic          fetch, exec1, exec2, mem_fetch_req, irq_pulse, active, timeout_fault;
  logic [CW-1:0] instr_count;

  always #5 clk = ~clk;

  cpu_sequencer #(.STALL_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk           (clk),
    .reset         (reset),
    .waitrequest   (waitrequest),
    .data_access   (data_access),
    .long_op_busy  (long_op_busy),
    .pc_halt       (pc_halt),
    .interrupt_req (interrupt_req),
    .fetch         (fetch),
    .exec1         (exec1),
    .exec2         (exec2),
    .mem_fetch_req (mem_fetch_req),
    .irq_pulse     (irq_pulse),
    .active        (active),
    .timeout_fault (timeout_fault),
    .instr_count   (instr_count)
  );

  int total = 0;
  int passed = 0;

  // reference model state
  bit   m_pending = 0;
  bit   m_prev = 0;
  int   m_count = 0;
  bit   rand_irq = 0;
  logic irq_q[$];
  int   obs_fetch, obs_e1, obs_stall, obs_e2, obs_pulse;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic rb();
    return logic'($urandom_range(1));
  endfunction

  // {fetch, exec1, exec2, mem_fetch_req, irq_pulse, active, timeout_fault}
  function automatic logic [6:0] exp_out(input int kind, input bit pulse);
    case (kind)
      K_FETCH: return 7'b1001010;
      K_E1:    return {1'b0, 1'b1, 1'b0, 1'b0, pulse, 1'b1, 1'b0};
      K_STALL: return 7'b0000010;
      K_E2:    return 7'b0010010;
      K_FAULT: return 7'b0000001;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic logic [6:0] outs();
    return {fetch, exec1, exec2, mem_fetch_req, irq_pulse, active, timeout_fault};
  endfunction

  // Called at a negedge: compare this cycle's outputs, drive this cycle's
  // inputs, advance the model, wait for the next negedge.
  task automatic cyc(input int kind, input bit first_e1, input logic wr, input logic da,
                     input logic lb, input logic ph, input bit flush);
    logic ir;
    bit   pulse, edge_s;
    if (irq_q.size() > 0) ir = irq_q.pop_front();
    else if (rand_irq)     ir = ($urandom_range(3) == 0) ? !m_prev : m_prev;
    else                   ir = 1'b0;
    pulse = first_e1 && m_pending;
    check($sformatf("outputs phase%0d", kind), 32'(outs()), 32'(exp_out(kind, pulse)));
    check("instr_count", 32'(instr_count), 32'(m_count));
    obs_fetch += int'(fetch);
    obs_e1    += int'(exec1);
    obs_e2    += int'(exec2);
    obs_pulse += int'(irq_pulse);
    obs_stall += int'(active & ~fetch & ~exec1 & ~exec2);
    waitrequest   = wr;
    data_access   = da;
    long_op_busy  = lb;
    pc_halt       = ph;
    interrupt_req = ir;
    edge_s = ir && !m_prev;
    m_prev = ir;
    if (flush)       m_pending = 0;
    else if (edge_s) m_pending = 1;
    else if (pulse)  m_pending = 0;
    if (kind == K_E2) m_count = (m_count + 1) % (1 << CW);
    @(negedge clk);
  endtask

  task automatic clear_obs();
    obs_fetch = 0; obs_e1 = 0; obs_stall = 0; obs_e2 = 0; obs_pulse = 0;
  endtask

  // One instruction: wf fetch waits, de data-access waits, lb cycles of
  // long_op_busy (high from EXEC1). end_st: 0 normal, 1 halted, 2 fault.
  task automatic instr(input int wf, input int de, input int lb, input bit halt, output int end_st);
    bit   first;
    logic da, wr;
    end_st = 0;
    for (int k = 1; k <= wf; k++) begin
      cyc(K_FETCH, 0, 1'b1, rb(), rb(), rb(), k == TO);
      if (k == TO) begin end_st = 2; return; end
    end
    cyc(K_FETCH, 0, 1'b0, rb(), rb(), rb(), 0);
    first = 1;
    for (int k = 1; k <= de; k++) begin
      cyc(K_E1, first, 1'b1, 1'b1, rb(), rb(), k == TO);
      first = 0;
      if (k == TO) begin end_st = 2; return; end
    end
    if (de > 0) begin da = 1'b1; wr = 1'b0; end
    else begin da = rb(); wr = da ? 1'b0 : rb(); end
    cyc(K_E1, first, wr, da, logic'(lb > 0), rb(), 0);
    for (int k = 1; k <= lb; k++) begin
      cyc(K_STALL, 0, rb(), rb(), logic'(k < lb), rb(), k == TO);
      if (k == TO) begin end_st = 2; return; end
    end
    cyc(K_E2, 0, rb(), rb(), rb(), halt, halt);
    end_st = halt ? 1 : 0;
  endtask

  task automatic tail(input int kind, input int n);
    for (int i = 0; i < n; i++) cyc(kind, 0, rb(), rb(), rb(), rb(), 1);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    waitrequest = 0; data_access = 0; long_op_busy = 0; pc_halt = 0; interrupt_req = 0;
    #1;
    check("reset outputs immediate", 32'(outs()), 32'd0);
    repeat (3) @(negedge clk);
    check("reset outputs held", 32'(outs()), 32'd0);
    check("reset instr_count", 32'(instr_count), 32'd0);
    m_pending = 0; m_prev = 0; m_count = 0;
    reset = 1'b1;
    cyc(K_BOOT, 0, rb(), rb(), rb(), rb(), 0);
  endtask

  typedef struct {
    int wf, de, lb;
    bit halt;
    int e_fetch, e_e1, e_stall, e_e2, e_end;
  } row_t;

  row_t tbl[10];
  int   st;

  initial begin
    tbl[0] = '{0, 0, 0, 0, 1, 1, 0, 1, 0};
    tbl[1] = '{5, 0, 0, 0, 6, 1, 0, 1, 0};
    tbl[2] = '{0, 2, 0, 0, 1, 3, 0, 1, 0};
    tbl[3] = '{0, 0, 4, 0, 1, 1, 4, 1, 0};
    tbl[4] = '{7, 0, 0, 0, 8, 1, 0, 1, 0};
    tbl[5] = '{0, 7, 0, 0, 1, 8, 0, 1, 0};
    tbl[6] = '{3, 1, 2, 1, 4, 2, 2, 1, 1};
    tbl[7] = '{8, 0, 0, 0, 8, 0, 0, 0, 2};
    tbl[8] = '{0, 8, 0, 0, 1, 8, 0, 0, 2};
    tbl[9] = '{2, 0, 6, 0, 3, 1, 6, 1, 0};

    @(negedge clk);
    do_reset();

    // table-driven stall/watchdog vectors
    for (int i = 0; i < 10; i++) begin
      clear_obs();
      instr(tbl[i].wf, tbl[i].de, tbl[i].lb, tbl[i].halt, st);
      check($sformatf("row%0d fetch cycles", i), 32'(obs_fetch), 32'(tbl[i].e_fetch));
      check($sformatf("row%0d exec1 cycles", i), 32'(obs_e1),    32'(tbl[i].e_e1));
      check($sformatf("row%0d stall cycles", i), 32'(obs_stall), 32'(tbl[i].e_stall));
      check($sformatf("row%0d exec2 cycles", i), 32'(obs_e2),    32'(tbl[i].e_e2));
      if (tbl[i].e_end != 0) begin
        tail((tbl[i].e_end == 2) ? K_FAULT : K_HALT, 5);
        do_reset();
      end
    end

    // halt on instruction 7, later interrupt edge ignored
    do_reset();
    rand_irq = 1;
    for (int i = 1; i <= 6; i++) begin
      instr($urandom_range(2), $urandom_range(1), $urandom_range(2), 0, st);
    end
    instr(1, 0, 1, 1, st);
    rand_irq = 0;
    clear_obs();
    irq_q = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    tail(K_HALT, 6);
    check("halted instr_count", 32'(instr_count), 32'd7);
    check("halted irq pulses", 32'(obs_pulse), 32'd0);

    // interrupt: single rise during FETCH
    do_reset();
    clear_obs();
    irq_q = '{1'b1, 1'b1, 1'b1};
    instr(0, 0, 0, 0, st);
    irq_q = '{1'b1, 1'b1, 1'b0};
    instr(0, 0, 0, 0, st);
    check("irq single edge pulses", 32'(obs_pulse), 32'd1);

    // two edges before delivery coalesce
    clear_obs();
    irq_q = '{1'b1, 1'b0, 1'b1, 1'b0};
    instr(3, 0, 0, 0, st);
    instr(0, 0, 0, 0, st);
    check("irq coalesced pulses", 32'(obs_pulse), 32'd1);

    // edge during the delivery cycle re-arms for the next instruction
    clear_obs();
    irq_q = '{1'b1, 1'b0, 1'b1, 1'b1};
    instr(1, 0, 0, 0, st);
    instr(0, 0, 0, 0, st);
    check("irq redelivery pulses", 32'(obs_pulse), 32'd2);

    // reset asserted in STALL with an interrupt pending
    cyc(K_FETCH, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    irq_q = '{1'b1, 1'b1};
    cyc(K_E1, 1, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    cyc(K_STALL, 0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    #2;
    do_reset();
    clear_obs();
    instr(0, 0, 0, 0, st);
    instr(1, 0, 0, 0, st);
    check("no pulse after reset", 32'(obs_pulse), 32'd0);

    // randomized instruction stream against the model
    rand_irq = 1;
    for (int i = 0; i < 60; i++) begin
      instr($urandom_range(3), $urandom_range(2), $urandom_range(3),
            ($urandom_range(24) == 0), st);
      if (st != 0) begin
        tail(K_HALT, 2);
        do_reset();
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
